aes_stream_bridge: RTL and testbench
====================================

# aes_stream_bridge

Adapter between the 32-bit AXI-Stream ports of the AES IP and the 128-bit block interface of `aes_module`. It gathers four input beats into one 128-bit block and runs the core's start/done handshake. It then scatters the 128-bit result as four output beats. It sits directly upstream and downstream of the core inside `aes_v1_0`, replacing ad-hoc glue between `s00_axis`/`m00_axis` and the core.

## Interface
- `DONE_TIMEOUT`, 64: max cycles waited for each core `aes_done` edge before aborting.
- `s00_axis_aclk`  in  1  single clock for the whole block.
- `s00_axis_aresetn`  in  1  asynchronous, active-low reset.
- `s00_axis_tdata`  in  32  input beat.
- `s00_axis_tvalid` / `s00_axis_tready`  in / out  1  input handshake.
- `s00_axis_tlast`  in  1  last beat of packet.
- `m00_axis_tdata`  out  32  output beat.
- `m00_axis_tvalid` / `m00_axis_tready`  out / in  1  output handshake.
- `m00_axis_tlast`  out  1  last beat of packet.
- `cfg_mode`  in  2  from AXI-Lite register: 00 ENCRYPT, 01 DECRYPT, 10 EXPAND_KEY, 11 reserved (treated as ENCRYPT).
- `aes_din`  out  128  block to core.
- `aes_mode`  out  2  latched mode to core.
- `aes_start`  out  1  core start request.
- `aes_done`  in  1  core done; high while idle, low while busy.
- `aes_dout`  in  128  core result.
- `busy`  out  1  high in any state except GATHER with beat count 0.
- `err_partial` / `err_timeout`  out  1  sticky error flags, cleared only by reset.

## Operation
- States: GATHER, START, WAIT_LOW, WAIT_DONE, EMIT.
- GATHER:
  - `s00_axis_tready`=1; a 2-bit beat counter counts 0..3.
  - Beat k goes to `aes_din[127-32k -: 32]` (first beat is MSW, big-endian).
  - `cfg_mode` is latched into `aes_mode` on beat 0.
  - `s00_axis_tlast` is recorded on beat 3.
  - After beat 3 is accepted: go to START.
- START: `aes_start`=1, then go to WAIT_LOW.
- WAIT_LOW: `aes_start` held 1. When `aes_done`=0, go to WAIT_DONE.
- WAIT_DONE: `aes_start` held 1. When `aes_done`=1:
  - capture `aes_dout` into the output shifter;
  - drop `aes_start` to 0;
  - go to EMIT, or to GATHER if the mode is EXPAND_KEY (no output beats).
- EMIT:
  - `m00_axis_tvalid`=1; `m00_axis_tdata` = `dout[127:96]` first, then lower words.
  - The beat advances only on tvalid&tready.
  - `m00_axis_tlast` = recorded tlast, on beat 3 only.
  - After beat 3 handshakes: go to GATHER.
- Timeout: a counter runs in WAIT_LOW and WAIT_DONE. On reaching `DONE_TIMEOUT` (each wait):
  - set `err_timeout`;
  - drop `aes_start`;
  - discard the block and go to GATHER.
- Partial block: `s00_axis_tlast` on beats 0–2 is handled per Configuration.
- Reserved mode: processed as ENCRYPT.

## Timing
- Reset values: all tready/tvalid/tlast = 0, `aes_start`=0, `aes_din`=0, `aes_mode`=00, `busy`=0, both error flags = 0. State is GATHER with count 0.
- `s00_axis_tready` rises in the first cycle after reset deassertion.
- Reset asserted mid-block (any state): all outputs return to reset values asynchronously, including `aes_start`. The partial block is lost.
- Last input beat accepted at edge N: `aes_start`=1 from N+1. `aes_start` falls on the edge after `aes_done` is seen high in WAIT_DONE. `m00_axis_tvalid` rises on that same edge.
- The input side is stalled (tready=0) from START through the end of EMIT; there is no overlap of blocks.
- Output stability: while tvalid=1 and tready=0, `m00_axis_tdata`/`tlast` hold.
- Simultaneous events: `aes_done` high in the same cycle WAIT_LOW is entered is ignored; WAIT_LOW waits for the low.

## Configuration
- `AES_STREAM_PAD_EN` defined:
  - tlast on beat k<3 zero-fills the remaining words and starts the block immediately;
  - output is 4 beats with tlast on beat 3;
  - `err_partial` is never set.
- Not defined:
  - the partial block is dropped;
  - `err_partial` is set;
  - the FSM returns to GATHER count 0;
  - no core start and no output.

## Structure
- Shared package `aes_stream_pkg` holds:
  - mode constants `AES_MODE_ENCRYPT`, `AES_MODE_DECRYPT`, `AES_MODE_EXPAND_KEY`;
  - the state encoding;
  - `AES_BEATS` = 4 and `AES_BLOCK_W` = 128.
- One sub-module `aes_beat_shifter`: a 128-bit register with 32-bit load/shift and a beat counter, instantiated twice (gather, emit).

## Test plan
- EXPAND_KEY with beats 00010203, 04050607, 08090a0b, 0c0d0e0f -> core sees din 000102…0f with mode 10; no m00 beats are emitted; `busy` returns to 0.
- ENCRYPT with beats 00112233, 44556677, 8899aabb, ccddeeff plus tlast -> out 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; tlast on the 4th beat only.
- DECRYPT of that ciphertext -> out 00112233 … ccddeeff. Backpressure `m00_axis_tready` low for 5 cycles mid-packet -> data holds, no beat is lost or duplicated.
- tlast on beat 1 -> with PAD_EN: din = 00112233_44556677_00000000_00000000, four output beats. Without PAD_EN: `err_partial`=1 and no output.
- Core model never drops `aes_done` -> `err_timeout`=1 after 64 cycles, `aes_start`=0, and the next block processes normally.
- Reset asserted in WAIT_DONE -> `aes_start`, `m00_axis_tvalid` and `busy` go to 0 immediately; a clean block afterwards gives the correct ciphertext.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared mode constants, block geometry and FSM encoding for aes_stream_bridge
package aes_stream_pkg;
    localparam int AES_BEATS   = 4;
    localparam int AES_BLOCK_W = 128;
    localparam logic [1:0] AES_MODE_ENCRYPT    = 2'b00;
    localparam logic [1:0] AES_MODE_DECRYPT    = 2'b01;
    localparam logic [1:0] AES_MODE_EXPAND_KEY = 2'b10;
    typedef enum logic [2:0] {ST_GATHER, ST_START, ST_WAIT_LOW, ST_WAIT_DONE, ST_EMIT} state_t;
endpackage

// File: rtl/aes_stream_bridge_shifter.sv
// aes_beat_shifter: 128-bit block register with 32-bit word load, block load and a beat counter
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the block and the counter (highest priority)
//   ld / blk   : load a whole block, counter to 0
//   wr / word  : write word into slot cnt (slot 0 = MSW), counter advances
//   adv        : advance the counter only (block is read out by slot index)
//   data, cnt  : block contents and current beat
module aes_beat_shifter
    import aes_stream_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   ld,
    input  logic                   wr,
    input  logic                   adv,
    input  logic [31:0]            word,
    input  logic [AES_BLOCK_W-1:0] blk,
    output logic [AES_BLOCK_W-1:0] data,
    output logic [1:0]             cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (ld) begin
            data <= blk;
            cnt  <= '0;
        end else if (wr) begin
            data[(AES_BEATS - 1 - int'(cnt)) * 32 +: 32] <= word;
            cnt <= cnt + 2'd1;
        end else if (adv) begin
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/aes_stream_bridge.sv
// aes_stream_bridge: 32-bit AXI-Stream <-> 128-bit aes_module block adapter with start/done handshake
//   s00_axis_*        : input stream (4 beats per block, first beat = MSW)
//   m00_axis_*        : output stream (4 beats per block, MSW first)
//   cfg_mode          : 00 enc, 01 dec, 10 expand key, 11 treated as enc; latched on beat 0
//   aes_din/mode/start: block, mode and start request to the core
//   aes_done/dout     : core done (high when idle) and result
//   busy              : low only when waiting for beat 0
//   err_partial/err_timeout : sticky error flags, cleared only by reset
//   AES_STREAM_PAD_EN : when defined, tlast before beat 3 zero-fills and runs the block;
//                       otherwise the partial block is dropped and err_partial is set
module aes_stream_bridge
    import aes_stream_pkg::*;
#(
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_aresetn,
    input  logic [31:0]            s00_axis_tdata,
    input  logic                   s00_axis_tvalid,
    output logic                   s00_axis_tready,
    input  logic                   s00_axis_tlast,
    output logic [31:0]            m00_axis_tdata,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic                   m00_axis_tlast,
    input  logic [1:0]             cfg_mode,
    output logic [AES_BLOCK_W-1:0] aes_din,
    output logic [1:0]             aes_mode,
    output logic                   aes_start,
    input  logic                   aes_done,
    input  logic [AES_BLOCK_W-1:0] aes_dout,
    output logic                   busy,
    output logic                   err_partial,
    output logic                   err_timeout
);
    localparam int TW = $clog2(DONE_TIMEOUT);
    state_t state, nxt;
    logic rdy_q, tlast_q, acc, fin, part_hit, to_hit, tmo, g_clr, e_ld, e_adv;
    logic [TW-1:0] tcnt;
    logic [1:0] g_cnt, e_cnt;
    logic [AES_BLOCK_W-1:0] e_data;
    // rdy_q keeps tready low during reset and for the edge that releases it
    assign s00_axis_tready = rdy_q && state == ST_GATHER;
    assign acc             = s00_axis_tvalid && s00_axis_tready;
    assign fin             = acc && (g_cnt == 2'd3 || s00_axis_tlast);
`ifdef AES_STREAM_PAD_EN
    assign part_hit        = 1'b0;
`else
    assign part_hit        = acc && s00_axis_tlast && g_cnt != 2'd3;
`endif
    assign aes_start       = state inside {ST_START, ST_WAIT_LOW, ST_WAIT_DONE};
    assign m00_axis_tvalid = state == ST_EMIT;
    assign m00_axis_tlast  = m00_axis_tvalid && e_cnt == 2'd3 && tlast_q;
    assign m00_axis_tdata  = e_data[(AES_BEATS - 1 - int'(e_cnt)) * 32 +: 32];
    assign busy            = !(state == ST_GATHER && g_cnt == 2'd0);
    assign to_hit          = tcnt == TW'(DONE_TIMEOUT - 1);
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) state <= ST_GATHER;
        else state <= nxt;
    end
    always_comb begin
        nxt   = state;
        g_clr = 1'b0;
        e_ld  = 1'b0;
        e_adv = 1'b0;
        tmo   = 1'b0;
        case (state)
            ST_GATHER: begin
                g_clr = part_hit;
                nxt   = (fin && !part_hit) ? ST_START : ST_GATHER;
            end
            ST_START: nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                tmo   = aes_done && to_hit;
                g_clr = tmo;
                nxt   = !aes_done ? ST_WAIT_DONE : tmo ? ST_GATHER : ST_WAIT_LOW;
            end
            ST_WAIT_DONE: begin
                tmo   = !aes_done && to_hit;
                e_ld  = aes_done;
                g_clr = aes_done || tmo;
                nxt   = aes_done ? (aes_mode == AES_MODE_EXPAND_KEY ? ST_GATHER : ST_EMIT)
                      : tmo ? ST_GATHER : ST_WAIT_DONE;
            end
            ST_EMIT: begin
                e_adv = m00_axis_tready;
                nxt   = (m00_axis_tready && e_cnt == 2'd3) ? ST_GATHER : ST_EMIT;
            end
            default: nxt = ST_GATHER;
        endcase
    end
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            rdy_q       <= 1'b0;
            tlast_q     <= 1'b0;
            aes_mode    <= AES_MODE_ENCRYPT;
            tcnt        <= '0;
            err_partial <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            // restarts for each wait state so every wait gets the full budget
            tcnt  <= (nxt == state && (state == ST_WAIT_LOW || state == ST_WAIT_DONE)) ? tcnt + 1'b1 : '0;
            if (acc && g_cnt == 2'd0)
                aes_mode <= (cfg_mode == AES_MODE_DECRYPT || cfg_mode == AES_MODE_EXPAND_KEY) ? cfg_mode : AES_MODE_ENCRYPT;
            if (fin) tlast_q <= s00_axis_tlast;
            if (part_hit) err_partial <= 1'b1;
            if (tmo) err_timeout <= 1'b1;
        end
    end
    aes_beat_shifter u_gather (
        .clk(s00_axis_aclk), .rst_n(s00_axis_aresetn), .clr(g_clr), .ld(1'b0), .wr(acc), .adv(1'b0),
        .word(s00_axis_tdata), .blk('0), .data(aes_din), .cnt(g_cnt)
    );
    aes_beat_shifter u_emit (
        .clk(s00_axis_aclk), .rst_n(s00_axis_aresetn), .clr(1'b0), .ld(e_ld), .wr(1'b0), .adv(e_adv),
        .word(32'h0), .blk(aes_dout), .data(e_data), .cnt(e_cnt)
    );
endmodule

// File: tb/tb_aes_stream_bridge.sv
// tb_aes_stream_bridge: randomized self-checking bench with a behavioural core model and stream scoreboard
module tb_aes_stream_bridge;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] s_tdata = '0, m_tdata;
    logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic m_tvalid, m_tready = 1'b0, m_tlast;
    logic [1:0] cfg_mode = '0, aes_mode;
    logic [127:0] aes_din, aes_dout = '0;
    logic aes_start, aes_done = 1'b1, busy, err_partial, err_timeout;
    int n_cmp = 0, n_bad = 0, n_out = 0, st_cnt = 0, lat_fix = 0, base, t;
    logic stuck = 1'b0, bp = 1'b0, manual = 1'b1;
    logic [127:0] exp_din[$];
    logic [1:0] exp_mode[$];
    logic [32:0] exp_q[$];
    logic [127:0] pt = 128'h00112233_44556677_8899aabb_ccddeeff;
    logic [127:0] ct = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    logic [127:0] key = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    logic [127:0] rblk, pad_blk;
    logic [1:0] rmode;
    logic rlast;

    always #5 clk = ~clk;

    aes_stream_bridge #(.DONE_TIMEOUT(64)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready), .s00_axis_tlast(s_tlast),
        .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready), .m00_axis_tlast(m_tlast),
        .cfg_mode(cfg_mode), .aes_din(aes_din), .aes_mode(aes_mode), .aes_start(aes_start),
        .aes_done(aes_done), .aes_dout(aes_dout), .busy(busy),
        .err_partial(err_partial), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core stand-in: the two reference vectors map to each other, anything else gets a mode-dependent scramble
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [1:0] m);
        if (m == 2'd0 && d == pt) return ct;
        if (m == 2'd1 && d == ct) return pt;
        return {d[95:0], d[127:96]} ^ {4{m, 30'h2a5a5a5a}};
    endfunction

    // Records what the core is expected to see and which beats must come out
    task automatic expect_block(input logic [127:0] blk, input logic [1:0] mode, input logic last);
        logic [1:0] eff;
        logic [127:0] r;
        eff = (mode == 2'd3) ? 2'd0 : mode;
        exp_din.push_back(blk);
        exp_mode.push_back(eff);
        if (eff != 2'd2) begin
            r = core_fn(blk, eff);
            for (int k = 0; k < 4; k++) exp_q.push_back({k == 3 && last, r[127 - 32*k -: 32]});
        end
    endtask

    task automatic send_block(input logic [127:0] blk, input logic [1:0] mode, input int nb, input logic last);
        int w;
        cfg_mode = mode;
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s_tdata  = blk[127 - 32*k -: 32];
            s_tlast  = (k == nb - 1) && last;
            s_tvalid = 1'b1;
            w = 0;
            while (!s_tready && w < 500) begin @(negedge clk); w++; end
            if (w >= 500) chk("in_ready_bound", s_tready, 1);
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && w < 3000) begin @(negedge clk); w++; end
        chk("idle_busy", busy, 0);
        chk("idle_pending", exp_q.size(), 0);
    endtask

    // Core model: on a rising start it checks the block, may keep done high for up to 2 cycles, then runs
    int ph = 0, cc = 0;
    logic pstart = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aes_done <= 1'b1;
            pstart   <= 1'b0;
            ph = 0;
        end else begin
            pstart <= aes_start;
            if (aes_start && !pstart) begin
                if (exp_din.size() != 0) begin
                    chk("core_din", aes_din, exp_din.pop_front());
                    chk("core_mode", aes_mode, exp_mode.pop_front());
                end else chk("core_start_extra", aes_start, 0);
                aes_dout <= core_fn(aes_din, aes_mode);
                if (!stuck) begin
                    cc = $urandom_range(0, 2);
                    if (cc == 0) begin
                        aes_done <= 1'b0;
                        ph = 2;
                        cc = (lat_fix != 0) ? lat_fix : $urandom_range(1, 6);
                    end else ph = 1;
                end
            end else if (ph == 1) begin
                if (cc <= 1) begin
                    aes_done <= 1'b0;
                    ph = 2;
                    cc = (lat_fix != 0) ? lat_fix : $urandom_range(1, 6);
                end else cc--;
            end else if (ph == 2) begin
                if (cc <= 1) begin
                    aes_done <= 1'b1;
                    ph = 0;
                end else cc--;
            end
        end
    end

    always @(negedge clk) if (!manual) m_tready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    always @(negedge clk) if (aes_start) st_cnt++;

    // Output scoreboard; also checks data/last hold while stalled
    logic stl_q = 1'b0, stl_l;
    logic [31:0] stl_d;
    logic [32:0] ex;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (stl_q && m_tvalid) begin
                chk("hold_data", m_tdata, stl_d);
                chk("hold_last", m_tlast, stl_l);
            end
            stl_q = m_tvalid && !m_tready;
            stl_d = m_tdata;
            stl_l = m_tlast;
            if (m_tvalid && m_tready) begin
                n_out++;
                if (exp_q.size() != 0) begin
                    ex = exp_q.pop_front();
                    chk("out_data", m_tdata, ex[31:0]);
                    chk("out_last", m_tlast, ex[32]);
                end else chk("out_extra", m_tvalid, 0);
            end
        end else stl_q = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_start", aes_start, 0);
        chk("rst_din", aes_din, 0);
        chk("rst_mode", aes_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errp", err_partial, 0);
        chk("rst_errt", err_timeout, 0);
        rst_n = 1'b1;
        #1 chk("rdy_same_cycle", s_tready, 0);
        @(negedge clk);
        chk("rdy_next_cycle", s_tready, 1);
        manual = 1'b0;
        // key expansion: no output beats
        expect_block(key, 2'd2, 1'b1);
        send_block(key, 2'd2, 4, 1'b1);
        wait_idle();
        chk("xk_outs", n_out, 0);
        // encrypt reference vector under random backpressure
        bp = 1'b1;
        base = n_out;
        expect_block(pt, 2'd0, 1'b1);
        send_block(pt, 2'd0, 4, 1'b1);
        wait_idle();
        chk("enc_outs", n_out - base, 4);
        // decrypt with a 5-cycle stall after two beats
        manual = 1'b1;
        m_tready = 1'b1;
        base = n_out;
        expect_block(ct, 2'd1, 1'b1);
        send_block(ct, 2'd1, 4, 1'b1);
        t = 0;
        while (n_out != base + 2 && t < 500) begin @(negedge clk); t++; end
        m_tready = 1'b0;
        chk("stall_at_beat2", n_out - base, 2);
        repeat (5) @(negedge clk);
        chk("stall_valid", m_tvalid, 1);
        m_tready = 1'b1;
        wait_idle();
        chk("dec_outs", n_out - base, 4);
        manual = 1'b0;
        // random blocks, all modes including reserved
        repeat (20) begin
            rblk  = {$urandom, $urandom, $urandom, $urandom};
            rmode = 2'($urandom_range(0, 3));
            rlast = 1'($urandom_range(0, 1));
            expect_block(rblk, rmode, rlast);
            send_block(rblk, rmode, 4, rlast);
        end
        wait_idle();
        // tlast on beat 1
        base = n_out;
`ifdef AES_STREAM_PAD_EN
        pad_blk = {pt[127:64], 64'h0};
        expect_block(pad_blk, 2'd0, 1'b1);
`endif
        send_block(pt, 2'd0, 2, 1'b1);
        wait_idle();
`ifdef AES_STREAM_PAD_EN
        chk("part_errp", err_partial, 0);
        chk("part_outs", n_out - base, 4);
`else
        chk("part_errp", err_partial, 1);
        chk("part_outs", n_out - base, 0);
        chk("part_start", aes_start, 0);
`endif
        // core that never drops done
        chk("pre_tmo_errt", err_timeout, 0);
        stuck = 1'b1;
        st_cnt = 0;
        base = n_out;
        exp_din.push_back(pt);
        exp_mode.push_back(2'd0);
        send_block(pt, 2'd0, 4, 1'b1);
        wait_idle();
        chk("tmo_errt", err_timeout, 1);
        chk("tmo_start", aes_start, 0);
        chk("tmo_outs", n_out - base, 0);
        chk("tmo_wait_len", st_cnt >= 64 && st_cnt <= 66, 1);
        stuck = 1'b0;
        base = n_out;
        expect_block(pt, 2'd0, 1'b1);
        send_block(pt, 2'd0, 4, 1'b1);
        wait_idle();
        chk("post_tmo_outs", n_out - base, 4);
        // reset while waiting for done
        lat_fix = 30;
        expect_block(pt, 2'd0, 1'b1);
        send_block(pt, 2'd0, 4, 1'b1);
        t = 0;
        while (!(aes_start && !aes_done) && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("wd_reached", aes_start && !aes_done, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_start", aes_start, 0);
        chk("arst_tvalid", m_tvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tready", s_tready, 0);
        chk("arst_errt", err_timeout, 0);
        chk("arst_errp", err_partial, 0);
        chk("arst_din", aes_din, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        lat_fix = 0;
        base = n_out;
        expect_block(pt, 2'd0, 1'b1);
        send_block(pt, 2'd0, 4, 1'b1);
        wait_idle();
        chk("post_rst_outs", n_out - base, 4);
        chk("din_left", exp_din.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
